mem_arb2: RTL and testbench

MEM_ARB2 -- requirements
Module: mem_arb2

---
 rtl/mem_arb2.sv | 109 ++++++++++
 tb/tb_mem_arb2.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb2.sv
// mem_arb2: two-requester, single-port memory arbiter.
// A round-robin winner is picked each cycle. The winner's request is forwarded
// to memory combinationally, and its read data valid is reported one cycle later.
module mem_arb2 (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_en,
    input  logic        r0_we,
    input  logic [15:0] r0_addr,
    input  logic [31:0] r0_dataW,
    output logic        r0_gnt,
    output logic        r0_rvalid,

    input  logic        r1_en,
    input  logic        r1_we,
    input  logic [15:0] r1_addr,
    input  logic [31:0] r1_dataW,
    output logic        r1_gnt,
    output logic        r1_rvalid,

    output logic [31:0] rdata,
    output logic [15:0] addr,
    output logic [31:0] dataW,
    output logic        en,
    output logic        we,
    input  logic [31:0] dataR,

    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          r_prio;     // port that wins a tie
    logic [1:0]    r_rd;       // one-hot pending read {rd1, rd0}
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;

    logic          w_gnt0;
    logic          w_gnt1;

    // Winner selection; reset forces both grants low.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (r0_en && (!r1_en || !r_prio)) begin
                w_gnt0 = 1'b1;
            end else if (r1_en) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    // Memory-side mux; the bus is idle at zero when there is no grant.
    always_comb begin
        en    = 1'b0;
        we    = 1'b0;
        addr  = AW'(0);
        dataW = DW'(0);
        if (w_gnt0) begin
            en    = 1'b1;
            we    = r0_we;
            addr  = r0_addr;
            dataW = r0_dataW;
        end else if (w_gnt1) begin
            en    = 1'b1;
            we    = r1_we;
            addr  = r1_addr;
            dataW = r1_dataW;
        end
    end

    // Priority toggle, pending-read tracking and saturating grant counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio <= 1'b0;
            r_rd   <= 2'b00;
            r_cnt0 <= CW'(0);
            r_cnt1 <= CW'(0);
        end else begin
            if (w_gnt0) begin
                r_prio <= 1'b1;
            end else if (w_gnt1) begin
                r_prio <= 1'b0;
            end
            r_rd <= {w_gnt1 & ~r1_we, w_gnt0 & ~r0_we};
            if (w_gnt0 && (r_cnt0 != CNT_MAX)) begin
                r_cnt0 <= r_cnt0 + CW'(1);
            end
            if (w_gnt1 && (r_cnt1 != CNT_MAX)) begin
                r_cnt1 <= r_cnt1 + CW'(1);
            end
        end
    end

    assign r0_gnt    = w_gnt0;
    assign r1_gnt    = w_gnt1;
    assign r0_rvalid = r_rd[0];
    assign r1_rvalid = r_rd[1];
    assign rdata     = dataR;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

endmodule

// File: tb/tb_mem_arb2.sv
// tb_mem_arb2: directed bench for mem_arb2 with hand-computed expectations.
module tb_mem_arb2;

    logic        clk;
    logic        reset;
    logic        r0_en, r0_we, r1_en, r1_we;
    logic [15:0] r0_addr, r1_addr;
    logic [31:0] r0_dataW, r1_dataW;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [31:0] rdata, dataW, dataR;
    logic [15:0] addr, cnt0, cnt1;
    logic        en, we;

    int n_chk;
    int n_err;
    int misses;

    mem_arb2 dut (
        .clk       (clk),
        .reset     (reset),
        .r0_en     (r0_en),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_dataW  (r0_dataW),
        .r0_gnt    (r0_gnt),
        .r0_rvalid (r0_rvalid),
        .r1_en     (r1_en),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_dataW  (r1_dataW),
        .r1_gnt    (r1_gnt),
        .r1_rvalid (r1_rvalid),
        .rdata     (rdata),
        .addr      (addr),
        .dataW     (dataW),
        .en        (en),
        .we        (we),
        .dataR     (dataR),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Never both grants high.
    always @(negedge clk) begin
        if (r0_gnt && r1_gnt) begin
            n_chk++;
            n_err++;
            $display("FAIL both_gnt got=11 exp=not-both at %0t", $time);
        end
    end

    initial begin
        n_chk = 0; n_err = 0; misses = 0;
        reset = 1'b1;
        r0_en = 0; r0_we = 0; r0_addr = 0; r0_dataW = 0;
        r1_en = 0; r1_we = 0; r1_addr = 0; r1_dataW = 0;
        dataR = 0;

        // Reset state, with a request pending to show reset gates grants.
        tick();
        r0_en = 1'b1;
        #1;
        chk("rst_gnt0", r0_gnt, 0);
        chk("rst_en", en, 0);
        chk("rst_we", we, 0);
        chk("rst_rv", {r1_rvalid, r0_rvalid}, 0);
        chk("rst_cnt", {cnt1, cnt0}, 0);
        tick();

        // Single read from r0 right after reset release.
        reset = 1'b0;
        r0_en = 1'b1; r0_we = 1'b0; r0_addr = 16'h0005;
        #1;
        chk("rd_gnt0", r0_gnt, 1);
        chk("rd_gnt1", r1_gnt, 0);
        chk("rd_en", en, 1);
        chk("rd_we", we, 0);
        chk("rd_addr", addr, 16'h0005);
        tick();
        r0_en = 1'b0; dataR = 32'h1234_5678;
        #1;
        chk("rd_rv0", r0_rvalid, 1);
        chk("rd_rv1", r1_rvalid, 0);
        chk("rd_rdata", rdata, 32'h1234_5678);
        chk("rd_cnt0", cnt0, 1);
        tick();
        chk("rd_rv0_done", r0_rvalid, 0);

        // Both requesting for 4 cycles after a fresh reset: 0,1,0,1.
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        r0_en = 1; r0_we = 0; r0_addr = 16'h1111;
        r1_en = 1; r1_we = 1; r1_addr = 16'h2222; r1_dataW = 32'hCAFE_0001;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_gnt0", r0_gnt, ((i % 2) == 0) ? 1 : 0);
            chk("rr_gnt1", r1_gnt, ((i % 2) == 1) ? 1 : 0);
            chk("rr_addr", addr, ((i % 2) == 0) ? 16'h1111 : 16'h2222);
            chk("rr_rv0", r0_rvalid, ((i % 2) == 1) ? 1 : 0);
            tick();
        end
        r0_en = 0; r1_en = 0;
        #1;
        chk("rr_cnt0", cnt0, 2);
        chk("rr_cnt1", cnt1, 2);
        chk("rr_rv0_end", r0_rvalid, 0);
        tick();

        // Lone write from r1.
        r1_en = 1; r1_we = 1; r1_addr = 16'h6300; r1_dataW = 32'hDEAD_BEEF;
        #1;
        chk("wr_gnt1", r1_gnt, 1);
        chk("wr_gnt0", r0_gnt, 0);
        chk("wr_en", en, 1);
        chk("wr_we", we, 1);
        chk("wr_addr", addr, 16'h6300);
        chk("wr_data", dataW, 32'hDEAD_BEEF);
        tick();
        r1_en = 0;
        #1;
        chk("wr_no_rv", {r1_rvalid, r0_rvalid}, 0);
        chk("wr_cnt1", cnt1, 3);
        tick();

        // Grant r0 so prio points at r1, then idle 10 cycles; prio must hold.
        r0_en = 1; r0_we = 0; r0_addr = 16'h00AA;
        #1;
        chk("pr_gnt0", r0_gnt, 1);
        tick();
        r0_en = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_en_we", {en, we}, 0);
            chk("idle_addr", addr, 0);
            chk("idle_data", dataW, 0);
            tick();
        end
        r0_en = 1; r1_en = 1; r1_we = 0; r1_addr = 16'h0BBB;
        #1;
        chk("pr_hold_gnt1", r1_gnt, 1);
        chk("pr_hold_gnt0", r0_gnt, 0);
        chk("pr_hold_addr", addr, 16'h0BBB);
        tick();
        r0_en = 0; r1_en = 0;
        tick();

        // Read granted, then reset asserted mid-cycle: no rvalid afterward.
        r0_en = 1; r0_we = 0; r0_addr = 16'h0077;
        #1;
        chk("mr_gnt0", r0_gnt, 1);
        reset = 1'b1;
        #1;
        chk("mr_rst_gnt0", r0_gnt, 0);
        chk("mr_rst_en", en, 0);
        tick();
        chk("mr_rst_rv0", r0_rvalid, 0);
        reset = 1'b0; r0_en = 0;
        tick();
        chk("mr_post_rv0", r0_rvalid, 0);
        chk("mr_cnt0", cnt0, 0);
        chk("mr_cnt1", cnt1, 0);
        r0_en = 1; r1_en = 1;
        #1;
        chk("mr_prio0", r0_gnt, 1);
        tick();
        r0_en = 0; r1_en = 0;

        // Continuous r0 reads until the counter saturates.
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        r0_en = 1; r0_we = 0; r0_addr = 16'h0001;
        #1;
        for (int i = 1; i <= 65540; i++) begin
            if (!r0_gnt) misses++;
            tick();
            if (i == 65534) chk("sat_fffe", cnt0, 16'hFFFE);
            if (i == 65535) chk("sat_ffff", cnt0, 16'hFFFF);
        end
        chk("sat_misses", misses, 0);
        chk("sat_end", cnt0, 16'hFFFF);
        chk("sat_cnt1", cnt1, 0);
        r0_en = 0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
